// File: rtl/regfile_sb.sv
// RV32I register file: 2 async read ports, 1 write port, hardwired x0, per-register busy scoreboard.
// Reads and a0 take 0 cycles, writes land at posedge; REGFILE_BYPASS_EN adds same-cycle write-through and early busy clear.
module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int A0_INDEX      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  output logic                     busy1,
  output logic                     busy2,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  output logic                     iss_ready,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     WE3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR = ADDRESS_WIDTH'(A0_INDEX);

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic                  wr_en;
  logic                  iss_set;

  assign wr_en = WE3 && (rd != '0);

  // A writeback retiring on the same index frees the single outstanding-write slot.
  assign iss_ready = !(iss_valid && (iss_rd != '0) && busy[iss_rd] && !(WE3 && (rd == iss_rd)));
  assign iss_set   = iss_valid && iss_ready && (iss_rd != '0);

  // Set is applied after clear so a new producer issued in the retiring cycle stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)   busy_nxt[rd]     = 1'b0;
    if (iss_set) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en) regs[rd] <= WD3;
      busy <= busy_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    RD1   = (rs1 == '0) ? '0 : ((wr_en && (rd == rs1)) ? WD3 : regs[rs1]);
    RD2   = (rs2 == '0) ? '0 : ((wr_en && (rd == rs2)) ? WD3 : regs[rs2]);
    a0    = (A0_ADDR == '0) ? '0 : ((wr_en && (rd == A0_ADDR)) ? WD3 : regs[A0_ADDR]);
    busy1 = busy[rs1] && (rs1 != '0) && !(WE3 && (rd == rs1));
    busy2 = busy[rs2] && (rs2 != '0) && !(WE3 && (rd == rs2));
  end
`else
  always_comb begin
    RD1   = (rs1 == '0) ? '0 : regs[rs1];
    RD2   = (rs2 == '0) ? '0 : regs[rs2];
    a0    = (A0_ADDR == '0) ? '0 : regs[A0_ADDR];
    busy1 = busy[rs1] && (rs1 != '0);
    busy2 = busy[rs2] && (rs2 != '0);
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, iss_rd, rd;
  logic [31:0] RD1, RD2, WD3, a0;
  logic        busy1, busy2, iss_valid, iss_ready, WE3;

  regfile_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .A0_INDEX(10)) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .RD1(RD1), .RD2(RD2),
    .busy1(busy1), .busy2(busy2), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_ready(iss_ready), .rd(rd), .WE3(WE3), .WD3(WD3), .a0(a0)
  );

  always #5 clk = ~clk;

  localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_RDY = 4, S_A0 = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int sig);
    case (sig)
      S_RD1:   return RD1;
      S_RD2:   return RD2;
      S_B1:    return {31'b0, busy1};
      S_B2:    return {31'b0, busy2};
      S_RDY:   return {31'b0, iss_ready};
      default: return a0;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, probe(e.sig), e.exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] ird, input logic we,
                       input logic [4:0] r, input logic [31:0] wd,
                       input logic [4:0] a, input logic [4:0] b);
    iss_valid = v; iss_rd = ird; WE3 = we; rd = r; WD3 = wd; rs1 = a; rs2 = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 5'd3, 0, 0, 0, 5'd5, 5'd6);
    #1;
    push("rst_rd1", S_RD1, 0);
    push("rst_b1", S_B1, 0);
    push("rst_rdy", S_RDY, 1);
    push("rst_a0", S_A0, 0);
    drain();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;

    // Mid-operation reset discards data and scoreboard state.
    next_cycle();
    drive(1, 5'd5, 1, 5'd5, 32'h1234, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 5'd5, 5'd5);
    push("x5_rd1", S_RD1, 32'h1234);
    push("x5_busy_setwins", S_B1, 1);
    sample();
    #1 rst_n = 1'b0;
    drive(1, 5'd5, 0, 0, 0, 5'd5, 5'd5);
    #1;
    push("mrst_rd1", S_RD1, 0);
    push("mrst_b2", S_B2, 0);
    push("mrst_rdy", S_RDY, 1);
    drain();
    drive(0, 0, 0, 0, 0, 5'd5, 5'd5);
    #1 rst_n = 1'b1;

    // x0 writes dropped, never busy
    next_cycle();
    drive(1, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0);
    push("x0_rd1_same", S_RD1, 0);
    push("x0_rdy", S_RDY, 1);
    sample();
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    push("x0_rd1", S_RD1, 0);
    push("x0_b1", S_B1, 0);
    push("x0_rd2", S_RD2, 0);
    sample();

    // RAW on x7
    next_cycle();
    drive(1, 5'd7, 0, 0, 0, 5'd7, 0);
    push("raw_b1_pre", S_B1, 0);
    sample();
    next_cycle();
    drive(0, 0, 0, 0, 0, 5'd7, 0);
    push("raw_b1", S_B1, 1);
    push("raw_rd1_old", S_RD1, 0);
    sample();
    next_cycle();
    drive(0, 0, 1, 5'd7, 32'hCAFE, 5'd7, 0);
    push("raw_rd1_wb", S_RD1, BYP ? 32'hCAFE : 32'h0);
    push("raw_b1_wb", S_B1, BYP ? 0 : 1);
    sample();
    next_cycle();
    drive(0, 0, 0, 0, 0, 5'd7, 0);
    push("raw_rd1_after", S_RD1, 32'hCAFE);
    push("raw_b1_after", S_B1, 0);
    sample();

    // WAW on x9
    next_cycle();
    drive(1, 5'd9, 0, 0, 0, 0, 5'd9);
    push("waw_rdy_first", S_RDY, 1);
    sample();
    next_cycle();
    drive(1, 5'd9, 0, 0, 0, 0, 5'd9);
    push("waw_rdy_stall", S_RDY, 0);
    push("waw_b2", S_B2, 1);
    sample();
    next_cycle();
    push("waw_rdy_stall2", S_RDY, 0);
    push("waw_b2_hold", S_B2, 1);
    sample();
    next_cycle();
    drive(1, 5'd9, 1, 5'd9, 32'h99, 0, 5'd9);
    push("waw_rdy_retire", S_RDY, 1);
    push("waw_rd2_wb", S_RD2, BYP ? 32'h99 : 32'h0);
    push("waw_b2_wb", S_B2, BYP ? 0 : 1);
    sample();
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 5'd9);
    push("waw_rd2_after", S_RD2, 32'h99);
    push("waw_b2_after", S_B2, 1);
    sample();
    next_cycle();
    drive(0, 0, 1, 5'd9, 32'h99, 0, 5'd9);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 5'd9);
    push("waw_b2_clr", S_B2, 0);
    sample();

    // a0 mirror
    next_cycle();
    drive(0, 0, 1, 5'd10, 32'h2A, 0, 0);
    push("a0_wb", S_A0, BYP ? 32'h2A : 32'h0);
    sample();
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    push("a0_after", S_A0, 32'h2A);
    sample();

    // Full sweep
    for (int r = 1; r < 32; r++) begin
      next_cycle();
      drive(0, 0, 1, 5'(r), 32'(r) * 32'h0101_0101, 0, 0);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int r = 1; r < 32; r++) begin
      rs1 = 5'(r);
      rs2 = 5'(32 - r);
      push($sformatf("sweep_rd1_x%0d", r), S_RD1, 32'(r) * 32'h0101_0101);
      push($sformatf("sweep_rd2_x%0d", 32 - r), S_RD2, 32'(32 - r) * 32'h0101_0101);
      #1;
      drain();
    end
    rs1 = 0;
    rs2 = 5'd31;
    push("sweep_rd1_x0", S_RD1, 0);
    push("sweep_rd2_x31", S_RD2, 32'd31 * 32'h0101_0101);
    push("sweep_a0", S_A0, 32'd10 * 32'h0101_0101);
    #1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
